// File: rtl/color_palette_ram_if.sv
// CPU access bus of the colour palette: level request, one-cycle ack.
// The CPU side uses the master modport; the palette uses the slave modport.
interface color_palette_ram_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );
endinterface

// File: rtl/color_palette_ram.sv
// Single-port colour palette shared by a two-stage pixel lookup pipeline and a CPU.
// The CPU uses free edges; after MAX_WAIT refused edges it takes the port by force.
module color_palette_ram #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int SEL_W    = 2,
  parameter int IDX_W    = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         pix_en,
  input  logic                         blank,
  input  logic [SEL_W-1:0]             gct,
  input  logic [ADDR_W-IDX_W-1:0]      cras,
  input  logic [(2**SEL_W)*IDX_W-1:0]  src_idx,
  color_palette_ram_if.slave           cpu,
  output logic [DATA_W-1:0]            pix_out,
  output logic                         pix_valid,
  output logic                         pix_stall
);

  localparam int NUM_SRC = 2**SEL_W;
  localparam int CNT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACK} cpu_state_t;

  cpu_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  wait_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] caddr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [ADDR_W-1:0] addr1_reg;
  logic              blank1_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [IDX_W-1:0]  src_slice [NUM_SRC];

  logic              port_free;
  logic              forced;
  logic              cpu_latch;
  logic              cpu_go;
  logic              stall_set;
  logic              ack_int;
  logic [ADDR_W-1:0] port_addr;
  logic [DATA_W-1:0] port_q;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_slice[gi] = src_idx[gi*IDX_W +: IDX_W];
  end

  // The pixel owns the port only when it advances with a visible index.
  assign port_free = ~(pix_en & ~blank1_reg);
  assign forced    = (wait_reg == CNT_W'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (cpu.cpu_req) state_next = S_PEND;
      S_PEND:  if (port_free || forced) state_next = S_ACK;
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_latch = (state_reg == S_IDLE) && cpu.cpu_req;
    cpu_go    = (state_reg == S_PEND) && (port_free || forced);
    stall_set = cpu_go && !port_free;
    ack_int   = (state_reg == S_ACK);
  end

  assign cpu.cpu_ack   = ack_int;
  assign cpu.cpu_rdata = rdata_reg;

  // One read port: the CPU address wins only on edges the CPU is granted.
  assign port_addr = cpu_go ? caddr_reg : addr1_reg;
  assign port_q    = mem[port_addr];

  always_ff @(posedge clk) begin
    if (cpu_go && we_reg) begin
      mem[caddr_reg] <= wdata_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wait_reg   <= '0;
      we_reg     <= 1'b0;
      caddr_reg  <= '0;
      wdata_reg  <= '0;
      addr1_reg  <= '0;
      blank1_reg <= 1'b1;
      pix_out    <= '0;
      pix_valid  <= 1'b0;
      pix_stall  <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      if (cpu_latch) begin
        we_reg    <= cpu.cpu_we;
        caddr_reg <= cpu.cpu_addr;
        wdata_reg <= cpu.cpu_wdata;
        wait_reg  <= '0;
      end else if ((state_reg == S_PEND) && !port_free && !forced) begin
        wait_reg <= wait_reg + 1'b1;
      end
      if (pix_en) begin
        addr1_reg  <= {cras, src_slice[gct]};
        blank1_reg <= blank;
        if (!stall_set) begin
          pix_out   <= blank1_reg ? '0 : port_q;
          pix_valid <= ~blank1_reg;
        end
      end
      pix_stall <= stall_set;
      if (cpu_go) begin
        rdata_reg <= we_reg ? wdata_reg : port_q;
      end
    end
  end

endmodule

// File: tb/tb_color_palette_ram.sv
// Randomized and directed bench for color_palette_ram against a behavioural palette model.
// Every cycle the model predicts all outputs; directed sequences pin down latencies.
module tb_color_palette_ram;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int SW = 2;
  localparam int IW = 8;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          pix_en;
  logic          blank;
  logic [SW-1:0] gct;
  logic [1:0]    cras;
  logic [31:0]   src_idx;
  logic [DW-1:0] pix_out;
  logic          pix_valid;
  logic          pix_stall;

  color_palette_ram_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  color_palette_ram #(
    .DATA_W(DW), .ADDR_W(AW), .SEL_W(SW), .IDX_W(IW), .MAX_WAIT(MW)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .pix_en    (pix_en),
    .blank     (blank),
    .gct       (gct),
    .cras      (cras),
    .src_idx   (src_idx),
    .cpu       (bus),
    .pix_out   (pix_out),
    .pix_valid (pix_valid),
    .pix_stall (pix_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int stall_seen = 0;
  bit alt_en = 1'b0;

  // Reference model: palette contents, the two pixel stages and one outstanding CPU request.
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  logic [AW-1:0] m_addr1;
  bit            m_blank1;
  logic [DW-1:0] m_pix;
  logic [DW-1:0] m_pix_prev;
  bit            m_valid, m_stall, m_ack;
  logic [DW-1:0] m_rdata;
  bit            m_busy;
  int            m_waited;
  bit            m_we;
  logic [AW-1:0] m_caddr;
  logic [DW-1:0] m_cwdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_addr1  = '0;
    m_blank1 = 1'b1;
    m_pix    = '0;
    m_valid  = 1'b0;
    m_stall  = 1'b0;
    m_ack    = 1'b0;
    m_rdata  = '0;
    m_busy   = 1'b0;
    m_waited = 0;
  endfunction

  function automatic void model_edge();
    bit owns, access, forced, busy_pre, ack_pre;
    if (!rst_b) begin
      model_reset();
      return;
    end
    owns     = pix_en && !m_blank1;
    access   = 1'b0;
    forced   = 1'b0;
    busy_pre = m_busy;
    ack_pre  = m_ack;
    if (m_busy) begin
      if (!owns) access = 1'b1;
      else if (m_waited == MW) begin
        access = 1'b1;
        forced = 1'b1;
      end else m_waited++;
    end
    if (pix_en) begin
      if (!forced) begin
        m_pix   = m_blank1 ? 16'h0000 : m_mem[m_addr1];
        m_valid = !m_blank1;
      end
      m_addr1  = {cras, 8'((src_idx >> (int'(gct) * 8)) & 32'hFF)};
      m_blank1 = blank;
    end
    m_stall = forced;
    m_ack   = access;
    if (access) begin
      if (m_we) begin
        m_mem[m_caddr] = m_cwdata;
        m_rdata = m_cwdata;
      end else begin
        m_rdata = m_mem[m_caddr];
      end
      m_busy = 1'b0;
    end
    if (!busy_pre && !ack_pre && bus.cpu_req) begin
      m_busy   = 1'b1;
      m_waited = 0;
      m_we     = bus.cpu_we;
      m_caddr  = bus.cpu_addr;
      m_cwdata = bus.cpu_wdata;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    m_pix_prev = m_pix;
    model_edge();
    #1;
    check_eq("pix_out",   32'(pix_out),       32'(m_pix));
    check_eq("pix_valid", 32'(pix_valid),     32'(m_valid));
    check_eq("pix_stall", 32'(pix_stall),     32'(m_stall));
    check_eq("cpu_ack",   32'(bus.cpu_ack),   32'(m_ack));
    check_eq("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_rdata));
    if (pix_stall === 1'b1) stall_seen++;
    if (alt_en) pix_en = ~pix_en;
  endtask

  // Holds the request until the DUT acks (bounded), drops it in the ack cycle.
  task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int exp_lat, input string tag);
    int lat;
    lat = 0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    do begin
      step();
      lat++;
    end while (bus.cpu_ack !== 1'b1 && lat < 64);
    bus.cpu_req = 1'b0;
    check_eq(tag, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    logic [DW-1:0] d;
    rst_b = 1'b1;
    pix_en = 1'b1; blank = 1'b1; gct = '0; cras = '0; src_idx = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    model_reset();
    #2 rst_b = 1'b0;
    step();
    step();
    rst_b = 1'b1;

    // Fill the palette through the CPU while blanked: every write takes 2 cycles.
    for (int a = 0; a < (1 << AW); a++) begin
      d = (a == (1 << AW) - 1) ? 16'h5A5A : DW'($urandom);
      cpu_op(1'b1, AW'(a), d, 2, "init_wr_lat");
      step();
    end

    // Blanked write then lookup through bank 1, source 2.
    cpu_op(1'b1, 10'h123, 16'hBEEF, 2, "blank_wr_lat");
    check_eq("blank_wr_rdata", 32'(bus.cpu_rdata), 32'h0000BEEF);
    step();
    blank = 1'b0; cras = 2'd1; gct = 2'd2; src_idx = 32'h0023_0000;
    step();
    step();
    check_eq("bank_pix", 32'(pix_out), 32'h0000BEEF);
    check_eq("bank_valid", 32'(pix_valid), 32'd1);

    // Source selection.
    blank = 1'b1;
    step();
    cpu_op(1'b1, 10'h030, 16'h0A0A, 2, "sel_wr_lat");
    step();
    blank = 1'b0; cras = 2'd0; src_idx = 32'h4030_2010; gct = 2'd2;
    step();
    step();
    check_eq("sel2_pix", 32'(pix_out), 32'h00000A0A);
    gct = 2'd0;
    step();
    step();
    check_eq("sel0_pix", 32'(pix_out), 32'(m_mem[10'h010]));

    // Blanked index.
    blank = 1'b1;
    step();
    step();
    check_eq("blank_pix", 32'(pix_out), 32'd0);
    check_eq("blank_valid", 32'(pix_valid), 32'd0);

    // Starvation: continuous active display forces a CPU slot.
    blank = 1'b0; gct = 2'd1;
    step();
    step();
    stall_seen = 0;
    cpu_op(1'b0, 10'h005, 16'h0000, MW + 2, "starve_lat");
    check_eq("starve_rdata", 32'(bus.cpu_rdata), 32'(m_mem[10'h005]));
    check_eq("starve_stall", 32'(pix_stall), 32'd1);
    check_eq("stall_hold", 32'(pix_out), 32'(m_pix_prev));
    step();
    step();
    check_eq("stall_pulses", 32'(stall_seen), 32'd1);

    // Alternating pixel enable: CPU uses the first disabled edge.
    stall_seen = 0;
    alt_en = 1'b1;
    step();
    if (pix_en !== 1'b1) step();
    cpu_op(1'b0, 10'h2AB, 16'h0000, 2, "alt_lat");
    check_eq("alt_rdata", 32'(bus.cpu_rdata), 32'(m_mem[10'h2AB]));
    for (int i = 0; i < 8; i++) step();
    check_eq("alt_no_stall", 32'(stall_seen), 32'd0);
    alt_en = 1'b0;
    pix_en = 1'b1;

    // Reset while a write is pending.
    step();
    step();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h3FF; bus.cpu_wdata = 16'h1234;
    step();
    bus.cpu_req = 1'b0;
    step();
    step();
    #2 rst_b = 1'b0;
    #1;
    model_reset();
    check_eq("rst_pix_out",   32'(pix_out),       32'd0);
    check_eq("rst_pix_valid", 32'(pix_valid),     32'd0);
    check_eq("rst_pix_stall", 32'(pix_stall),     32'd0);
    check_eq("rst_cpu_ack",   32'(bus.cpu_ack),   32'd0);
    check_eq("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    step();
    rst_b = 1'b1;
    blank = 1'b1;
    step();
    cpu_op(1'b0, 10'h3FF, 16'h0000, 2, "post_rst_lat");
    check_eq("rst_no_write", 32'(bus.cpu_rdata), 32'h00005A5A);
    step();

    // Random traffic on both sides.
    for (int i = 0; i < 3000; i++) begin
      pix_en        = ($urandom_range(0, 9) < 7);
      blank         = ($urandom_range(0, 3) == 0);
      gct           = SW'($urandom);
      cras          = 2'($urandom);
      src_idx       = $urandom;
      bus.cpu_req   = ($urandom_range(0, 2) == 0);
      bus.cpu_we    = 1'($urandom);
      bus.cpu_addr  = AW'($urandom);
      bus.cpu_wdata = DW'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
